// File: rtl/boton_emulador_rebote.sv
// Bouncing-button generator: turns clean press/release commands into a btn_out line
// that chatters pseudo-randomly for BOUNCE_CYCLES clocks before settling at the target.
module boton_emulador_rebote #(
    parameter int         BOUNCE_CYCLES = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_level,
    output logic       cmd_ready,
    output logic       btn_out,
    output logic       settled,
    output logic [3:0] bounce_count
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_BOUNCE  = 1'b1;
    // An all-zero seed would lock the LFSR up, so it is replaced by 01.
    localparam logic [7:0] SEED_EFF   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] TIMER_LOAD = 8'(BOUNCE_CYCLES - 1);

    logic [0:0] state;
    logic [7:0] lfsr;
    logic [7:0] timer;
    logic       target;
    logic       feedback;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

    // Fibonacci feedback for x^8+x^6+x^5+x^4+1 on a left-shifting register
    always_comb begin
        feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end

    // Event FSM, chatter generation and free-running LFSR
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            lfsr         <= SEED_EFF;
            timer        <= 8'd0;
            target       <= 1'b0;
            btn_out      <= 1'b0;
            cmd_ready    <= 1'b1;
            settled      <= 1'b1;
            bounce_count <= 4'd0;
        end else begin
            lfsr <= {lfsr[6:0], feedback};
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_level == btn_out) begin
                            bounce_count <= 4'd0;
                        end else begin
                            target       <= cmd_level;
                            btn_out      <= ~btn_out;
                            bounce_count <= 4'd1;
                            timer        <= TIMER_LOAD;
                            state        <= ST_BOUNCE;
                            cmd_ready    <= 1'b0;
                            settled      <= 1'b0;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (timer != 8'd0) begin
                        if (lfsr[0]) begin
                            btn_out      <= ~btn_out;
                            bounce_count <= sat_inc(bounce_count);
                        end
                        timer <= timer - 8'd1;
                    end else begin
                        // Forced settle: the line always ends at the commanded level.
                        btn_out <= target;
                        if (btn_out != target) begin
                            bounce_count <= sat_inc(bounce_count);
                        end
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        settled   <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    btn_out   <= target;
                    cmd_ready <= 1'b1;
                    settled   <= 1'b1;
                end
            endcase
        end
    end
endmodule
